jtag_tap_oversampled: RTL and testbench

// - Synthesizable IEEE 1149.1 TAP controller that consumes the SimJTAG pin outputs (TCK/TMS/TDI/TRSTn) and returns TDO.
// - Oversamples the JTAG pins on the system clock; no TCK clock domain. Sits between the JTAG pin driver and the debug/user register logic.
// - Provides IDCODE, BYPASS and one USER data register with a valid/ready update port and a capture port.

---
 rtl/jtag_tap_oversampled.sv | 190 +++++++++++++++++++
 tb/tb_jtag_tap_oversampled.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_oversampled.sv
// jtag_tap_oversampled: IEEE 1149.1 TAP controller that oversamples the JTAG pins
// on the system clock. There is no TCK clock domain.
// Instructions: IDCODE (5'h01), USER (5'h10), BYPASS (5'h1F). Any other code selects the 1-bit bypass register.
// Optional macro JTAG_TAP_SYNC_EN adds a 2-flop synchroniser on the pins.
// With the macro, pin-to-state latency is 3 clocks; without it, 2 clocks.
// tap_state is a debug view of the FSM in the IEEE 1149.1 state encoding.
// The TLR state is 4'hF and RTI is 4'hC.
// Handshake: dr_update_valid rises when Update-DR latches a USER value.
// While valid is high, dr_update_data holds still.
// The transfer completes on a clock where valid and ready are both 1.
// valid drops on the next clock unless a new update lands on that same clock.
module jtag_tap_oversampled #(
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
    parameter int          DR_W       = 32,
    parameter int          IR_W       = 5
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            jtag_TCK,
    input  logic            jtag_TMS,
    input  logic            jtag_TDI,
    input  logic            jtag_TRSTn,
    output logic            jtag_TDO_data,
    output logic            jtag_TDO_driven,
    output logic [IR_W-1:0] ir_q,
    input  logic [DR_W-1:0] dr_capture_data,
    output logic            dr_update_valid,
    output logic [DR_W-1:0] dr_update_data,
    input  logic            dr_update_ready,
    output logic            dr_overrun,
    output logic [3:0]      tap_state
);
    typedef enum logic [3:0] {
        TLR      = 4'hF, RTI      = 4'hC,
        SEL_DR   = 4'h7, CAP_DR   = 4'h6, SHIFT_DR = 4'h2, EXIT1_DR = 4'h1,
        PAUSE_DR = 4'h3, EXIT2_DR = 4'h0, UPD_DR   = 4'h5,
        SEL_IR   = 4'h4, CAP_IR   = 4'hE, SHIFT_IR = 4'hA, EXIT1_IR = 4'h9,
        PAUSE_IR = 4'hB, EXIT2_IR = 4'h8, UPD_IR   = 4'hD
    } tap_state_t;

    localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(1);
    localparam logic [IR_W-1:0] IR_USER   = IR_W'(16);

    logic tck_s, tms_s, tdi_s, trstn_s, tck_prev;
    logic rise, fall;

`ifdef JTAG_TAP_SYNC_EN
    logic [3:0] pins_meta;

    // Two-flop synchroniser; TRSTn idles high out of reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pins_meta                       <= 4'b1000;
            {trstn_s, tdi_s, tms_s, tck_s}  <= 4'b1000;
        end else begin
            pins_meta                       <= {jtag_TRSTn, jtag_TDI, jtag_TMS, jtag_TCK};
            {trstn_s, tdi_s, tms_s, tck_s}  <= pins_meta;
        end
    end
`else
    // Single register stage on the pins; TRSTn idles high out of reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            {trstn_s, tdi_s, tms_s, tck_s} <= 4'b1000;
        end else begin
            {trstn_s, tdi_s, tms_s, tck_s} <= {jtag_TRSTn, jtag_TDI, jtag_TMS, jtag_TCK};
        end
    end
`endif

    // Previous TCK sample for edge detection
    always_ff @(posedge clock) begin
        if (!resetn) tck_prev <= 1'b0;
        else         tck_prev <= tck_s;
    end

    assign rise = tck_s & ~tck_prev;
    assign fall = ~tck_s & tck_prev;

    tap_state_t state, state_next, graph_next;

    // FSM state register
    always_ff @(posedge clock) begin
        if (!resetn) state <= TLR;
        else         state <= state_next;
    end

    // TAP graph on TMS; synchronised TRSTn low wins over a coincident rise
    always_comb begin
        graph_next = state;
        case (state)
            TLR:      graph_next = tms_s ? TLR      : RTI;
            RTI:      graph_next = tms_s ? SEL_DR   : RTI;
            SEL_DR:   graph_next = tms_s ? SEL_IR   : CAP_DR;
            CAP_DR:   graph_next = tms_s ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: graph_next = tms_s ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: graph_next = tms_s ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: graph_next = tms_s ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: graph_next = tms_s ? UPD_DR   : SHIFT_DR;
            UPD_DR:   graph_next = tms_s ? SEL_DR   : RTI;
            SEL_IR:   graph_next = tms_s ? TLR      : CAP_IR;
            CAP_IR:   graph_next = tms_s ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: graph_next = tms_s ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: graph_next = tms_s ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: graph_next = tms_s ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: graph_next = tms_s ? UPD_IR   : SHIFT_IR;
            UPD_IR:   graph_next = tms_s ? SEL_DR   : RTI;
            default:  graph_next = TLR;
        endcase
        state_next = state;
        if (!trstn_s)  state_next = TLR;
        else if (rise) state_next = graph_next;
    end

    assign tap_state = state;

    logic [IR_W-1:0] ir_sr;
    logic [31:0]     idcode_sr;
    logic [DR_W-1:0] user_sr;
    logic            bypass_sr;
    logic            ir_side;
    logic            active_lsb;

    // Select the shift register whose LSB feeds TDO
    always_comb begin
        ir_side    = (state inside {SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR});
        active_lsb = bypass_sr;
        if (ir_side)                active_lsb = ir_sr[0];
        else if (ir_q == IR_IDCODE) active_lsb = idcode_sr[0];
        else if (ir_q == IR_USER)   active_lsb = user_sr[0];
    end

    // Register actions on TCK edges, using the state before the transition
    always_ff @(posedge clock) begin
        if (!resetn) begin
            ir_sr           <= '0;
            idcode_sr       <= '0;
            user_sr         <= '0;
            bypass_sr       <= 1'b0;
            ir_q            <= IR_IDCODE;
            jtag_TDO_data   <= 1'b0;
            jtag_TDO_driven <= 1'b0;
            dr_update_valid <= 1'b0;
            dr_update_data  <= '0;
            dr_overrun      <= 1'b0;
        end else begin
            if (dr_update_valid && dr_update_ready) dr_update_valid <= 1'b0;
            if (!trstn_s) begin
                ir_q            <= IR_IDCODE;
                jtag_TDO_driven <= 1'b0;
            end else if (rise) begin
                case (state)
                    CAP_IR:   ir_sr <= {{(IR_W-2){1'b0}}, 2'b01};
                    SHIFT_IR: ir_sr <= {tdi_s, ir_sr[IR_W-1:1]};
                    UPD_IR:   ir_q  <= ir_sr;
                    CAP_DR: begin
                        if (ir_q == IR_IDCODE)    idcode_sr <= IDCODE_VAL;
                        else if (ir_q == IR_USER) user_sr   <= dr_capture_data;
                        else                      bypass_sr <= 1'b0;
                    end
                    SHIFT_DR: begin
                        if (ir_q == IR_IDCODE)    idcode_sr <= {tdi_s, idcode_sr[31:1]};
                        else if (ir_q == IR_USER) user_sr   <= {tdi_s, user_sr[DR_W-1:1]};
                        else                      bypass_sr <= tdi_s;
                    end
                    UPD_DR: begin
                        if (ir_q == IR_USER) begin
                            // A consumer accepting on this same clock frees the slot
                            if (!dr_update_valid || dr_update_ready) begin
                                dr_update_data  <= user_sr;
                                dr_update_valid <= 1'b1;
                            end else begin
                                dr_overrun <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
                if (graph_next == TLR) begin
                    ir_q            <= IR_IDCODE;
                    jtag_TDO_driven <= 1'b0;
                end
            end else if (fall) begin
                jtag_TDO_data   <= active_lsb;
                jtag_TDO_driven <= (state == SHIFT_IR) || (state == SHIFT_DR);
            end
        end
    end

endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// tb_jtag_tap_oversampled: directed and randomized scans against a scan-level
// reference model of the TAP: capture value followed by TDI stream on TDO, update port rules.
module tb_jtag_tap_oversampled;
    localparam logic [31:0] IDCODE_VAL = 32'h1000_0001;
    localparam int          DR_W       = 32;
`ifdef JTAG_TAP_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam logic [3:0] ST_TLR      = 4'hF;
    localparam logic [3:0] ST_RTI      = 4'hC;
    localparam logic [3:0] ST_SHIFT_DR = 4'h2;

    logic            clock = 1'b0;
    logic            resetn;
    logic            jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
    logic            jtag_TDO_data, jtag_TDO_driven;
    logic [4:0]      ir_q;
    logic [DR_W-1:0] dr_capture_data;
    logic            dr_update_valid;
    logic [DR_W-1:0] dr_update_data;
    logic            dr_update_ready;
    logic            dr_overrun;
    logic [3:0]      tap_state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // reference model state
    logic [4:0]      ir_m;
    bit              valid_m, over_m;
    logic [DR_W-1:0] data_m;

    jtag_tap_oversampled #(.IDCODE_VAL(IDCODE_VAL), .DR_W(DR_W), .IR_W(5)) dut (
        .clock(clock), .resetn(resetn),
        .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn),
        .jtag_TDO_data(jtag_TDO_data), .jtag_TDO_driven(jtag_TDO_driven),
        .ir_q(ir_q), .dr_capture_data(dr_capture_data),
        .dr_update_valid(dr_update_valid), .dr_update_data(dr_update_data),
        .dr_update_ready(dr_update_ready), .dr_overrun(dr_overrun), .tap_state(tap_state)
    );

    // clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time budget expired (observed=running expected=finished)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One TCK period: TDO/driven sampled just before the rise; optional
    // one-clock ready pulse aligned to the clock that acts on the rise
    task automatic tck(input bit tms, input bit tdi, input bit rdy, output logic tdo, output logic drv);
        jtag_TMS = tms;
        jtag_TDI = tdi;
        repeat (4) @(negedge clock);
        tdo = jtag_TDO_data;
        drv = jtag_TDO_driven;
        jtag_TCK = 1'b1;
        if (rdy) begin
            repeat (LAT - 1) @(negedge clock);
            dr_update_ready = 1'b1;
            @(negedge clock);
            dr_update_ready = 1'b0;
            repeat (4 - LAT) @(negedge clock);
        end else begin
            repeat (4) @(negedge clock);
        end
        jtag_TCK = 1'b0;
    endtask

    // IR scan from RTI back to RTI
    task automatic ir_scan(input logic [4:0] v);
        logic o, d;
        logic [4:0] cap;
        cap = 5'b00001;
        tck(1, 0, 0, o, d);
        tck(1, 0, 0, o, d);
        tck(0, 0, 0, o, d);
        tck(0, 0, 0, o, d);
        for (int i = 0; i < 5; i++) begin
            tck(i == 4, v[i], 0, o, d);
            check("ir_tdo", o, cap[i]);
            check("ir_drv", d, 1);
        end
        tck(1, 0, 0, o, d);
        check("ir_drv_exit", d, 0);
        tck(0, 0, 0, o, d);
        ir_m = v;
        repeat (2) @(negedge clock);
        check("ir_q", ir_q, ir_m);
    endtask

    // DR scan of n bits from RTI back to RTI; model: TDO = capture bits then TDI bits
    task automatic dr_scan(input int n, input logic [63:0] din, input bit rdy, output logic [63:0] dout);
        logic o, d;
        int len;
        logic [63:0] capv;
        bit q[$];
        logic [DR_W-1:0] reg_after;
        len  = (ir_m == 5'h01) ? 32 : (ir_m == 5'h10) ? DR_W : 1;
        capv = (ir_m == 5'h01) ? 64'(IDCODE_VAL) : (ir_m == 5'h10) ? 64'(dr_capture_data) : 64'd0;
        for (int i = 0; i < len; i++) q.push_back(capv[i]);
        for (int i = 0; i < n; i++)   q.push_back(din[i]);
        tck(1, 0, 0, o, d);
        tck(0, 0, 0, o, d);
        tck(0, 0, 0, o, d);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            tck(i == n - 1, din[i], 0, o, d);
            dout[i] = o;
            check("dr_tdo", o, q[i]);
            check("dr_drv", d, 1);
        end
        tck(1, 0, 0, o, d);
        check("dr_drv_exit", d, 0);
        tck(0, 0, rdy, o, d);
        reg_after = '0;
        for (int j = 0; j < len; j++) reg_after[j] = q[n + j];
        if (ir_m == 5'h10) begin
            if (!valid_m || rdy) begin
                data_m  = reg_after;
                valid_m = 1'b1;
            end else begin
                over_m = 1'b1;
            end
        end else if (rdy) begin
            valid_m = 1'b0;
        end
        repeat (2) @(negedge clock);
        check("upd_valid", dr_update_valid, valid_m);
        check("upd_data", dr_update_data, data_m);
        check("overrun", dr_overrun, over_m);
    endtask

    task automatic consume();
        dr_update_ready = 1'b1;
        @(negedge clock);
        dr_update_ready = 1'b0;
        valid_m = 1'b0;
        repeat (2) @(negedge clock);
        check("consume_valid", dr_update_valid, valid_m);
    endtask

    // directed steps followed by randomized scans
    initial begin
        logic o, d;
        logic [63:0] dout;
        logic [4:0] irv;
        int n;
        resetn = 1'b0; jtag_TCK = 1'b0; jtag_TMS = 1'b1; jtag_TDI = 1'b0; jtag_TRSTn = 1'b1;
        dr_update_ready = 1'b0; dr_capture_data = '0;
        ir_m = 5'h01; valid_m = 0; over_m = 0; data_m = '0;
        repeat (3) @(negedge clock);
        check("rst_state", tap_state, ST_TLR);
        check("rst_ir", ir_q, 5'h01);
        check("rst_tdo", jtag_TDO_data, 0);
        check("rst_drv", jtag_TDO_driven, 0);
        check("rst_valid", dr_update_valid, 0);
        check("rst_data", dr_update_data, 0);
        check("rst_overrun", dr_overrun, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 5; i++) tck(1, 0, 0, o, d);
        repeat (4) @(negedge clock);
        check("tlr_state", tap_state, ST_TLR);
        check("tlr_ir", ir_q, 5'h01);
        check("tlr_drv", jtag_TDO_driven, 0);
        tck(0, 0, 0, o, d);
        repeat (2) @(negedge clock);
        check("rti_state", tap_state, ST_RTI);

        // IDCODE read straight out of reset
        dr_scan(32, {$urandom(), $urandom()}, 0, dout);
        check("idcode_stream", dout[31:0], 32'h1000_0001);

        // BYPASS: one-TCK delay from TDI to TDO
        ir_scan(5'h1F);
        dr_scan(4, 64'b1101, 0, dout);
        check("bypass_stream", dout[3:0], 4'b1010);

        // USER update, then overrun on a second update while still pending
        ir_scan(5'h10);
        dr_capture_data = $urandom();
        dr_scan(32, 64'hDEAD_BEEF, 0, dout);
        check("user_data", dr_update_data, 32'hDEAD_BEEF);
        check("user_valid", dr_update_valid, 1);
        dr_scan(32, 64'h1234_5678, 0, dout);
        check("user_overrun", dr_overrun, 1);
        check("user_data_kept", dr_update_data, 32'hDEAD_BEEF);

        // new update on the very clock the consumer accepts: accepted, no new overrun
        consume();
        dr_scan(32, 64'hCAFE_0001, 0, dout);
        dr_scan(32, 64'h0BAD_F00D, 1, dout);
        check("same_cycle_data", dr_update_data, 32'h0BAD_F00D);
        consume();

        // USER capture shows up LSB first on TDO
        dr_capture_data = 32'h0000_00A5;
        dr_scan(8, {$urandom(), $urandom()}, 0, dout);
        check("capture_a5", dout[7:0], 8'hA5);
        consume();

        // randomized scans
        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 3))
                0:       irv = 5'h01;
                1:       irv = 5'h10;
                2:       irv = 5'h1F;
                default: irv = 5'($urandom_range(0, 31));
            endcase
            ir_scan(irv);
            dr_capture_data = $urandom();
            n = $urandom_range(1, 40);
            dr_scan(n, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)), dout);
            if ($urandom_range(0, 1) == 1) consume();
        end

        // TRSTn mid Shift-DR, a TCK while held low must not move the FSM
        ir_scan(5'h10);
        tck(1, 0, 0, o, d);
        tck(0, 0, 0, o, d);
        tck(0, 0, 0, o, d);
        tck(0, 1, 0, o, d);
        check("pre_trst_state", tap_state, ST_SHIFT_DR);
        jtag_TRSTn = 1'b0;
        repeat (LAT + 2) @(negedge clock);
        check("trst_state", tap_state, ST_TLR);
        check("trst_drv", jtag_TDO_driven, 0);
        check("trst_ir", ir_q, 5'h01);
        tck(0, 0, 0, o, d);
        repeat (2) @(negedge clock);
        check("trst_hold", tap_state, ST_TLR);
        jtag_TRSTn = 1'b1;
        ir_m = 5'h01;
        repeat (4) @(negedge clock);
        tck(0, 0, 0, o, d);
        repeat (2) @(negedge clock);
        check("trst_rti", tap_state, ST_RTI);

        // resetn mid shift clears everything, including sticky overrun
        tck(1, 0, 0, o, d);
        tck(0, 0, 0, o, d);
        tck(0, 0, 0, o, d);
        tck(0, 1, 0, o, d);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("mid_rst_state", tap_state, ST_TLR);
        check("mid_rst_ir", ir_q, 5'h01);
        check("mid_rst_drv", jtag_TDO_driven, 0);
        check("mid_rst_tdo", jtag_TDO_data, 0);
        check("mid_rst_valid", dr_update_valid, 0);
        check("mid_rst_data", dr_update_data, 0);
        check("mid_rst_overrun", dr_overrun, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
